// File: rtl/mem_port_arbiter.sv
// Merges the instruction and data memory ports onto one shared bus with
// round-robin arbitration, registered request capture and a stuck-bus watchdog.
module mem_port_arbiter #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_valid_i,
  output logic                  imem_ready_o,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]            imem_we_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  input  logic                  dmem_valid_i,
  output logic                  dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  input  logic [3:0]            dmem_we_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  timeout_o,
  output logic                  timeout_sticky_o
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam int unsigned   CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  state_t                r_state;
  logic                  r_last_d;
  logic                  r_mem_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_we;
  logic [CW-1:0]         r_cnt;
  logic                  r_sticky;

  logic                  w_busy;
  logic                  w_expire;
  logic                  w_done;
  logic                  w_pick_d;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_busy   = (r_state != IDLE);
  // A ready arriving in the expiry cycle wins over the watchdog.
  assign w_expire = (TIMEOUT_CYCLES != 0) && w_busy && !mem_ready_i && (r_cnt == TMO);
  assign w_done   = w_busy && (mem_ready_i || w_expire);
  assign w_rdata  = w_expire ? ERR_RDATA : mem_rdata_i;
  assign w_pick_d = dmem_valid_i && (!imem_valid_i || !r_last_d);

  assign imem_ready_o     = w_done && (r_state == BUSY_I);
  assign dmem_ready_o     = w_done && (r_state == BUSY_D);
  assign imem_rdata_o     = imem_ready_o ? w_rdata : '0;
  assign dmem_rdata_o     = dmem_ready_o ? w_rdata : '0;
  assign mem_valid_o      = r_mem_valid;
  assign mem_addr_o       = r_addr;
  assign mem_wdata_o      = r_wdata;
  assign mem_we_o         = r_we;
  assign timeout_o        = w_expire;
  assign timeout_sticky_o = r_sticky | w_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_mem_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= '0;
      r_cnt       <= '0;
      r_sticky    <= 1'b0;
    end else begin
      if (w_expire) r_sticky <= 1'b1;
      case (r_state)
        IDLE: begin
          if (imem_valid_i || dmem_valid_i) begin
            r_state     <= w_pick_d ? BUSY_D : BUSY_I;
            r_last_d    <= w_pick_d;
            r_mem_valid <= 1'b1;
            r_addr      <= w_pick_d ? dmem_addr_i  : imem_addr_i;
            r_wdata     <= w_pick_d ? dmem_wdata_i : imem_wdata_i;
            r_we        <= w_pick_d ? dmem_we_i    : imem_we_i;
            r_cnt       <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (w_done) begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two random requesters and a random-latency
// memory, checked against a transaction-level model of grant order and completion.
module tb_mem_port_arbiter;

  localparam int unsigned TMO = 4;
  localparam logic [31:0] ERR = 32'hBAD0_0BAD;

  logic        clk, rst;
  logic        imem_valid_i, imem_ready_o, dmem_valid_i, dmem_ready_o;
  logic [31:0] imem_addr_i, imem_wdata_i, imem_rdata_o;
  logic [31:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
  logic [3:0]  imem_we_i, dmem_we_i, mem_we_o;
  logic        mem_valid_o, mem_ready_i, timeout_o, timeout_sticky_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_valid_i(imem_valid_i), .imem_ready_o(imem_ready_o), .imem_addr_i(imem_addr_i),
    .imem_wdata_i(imem_wdata_i), .imem_we_i(imem_we_i), .imem_rdata_o(imem_rdata_o),
    .dmem_valid_i(dmem_valid_i), .dmem_ready_o(dmem_ready_o), .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_we_i(dmem_we_i), .dmem_rdata_o(dmem_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
    .timeout_o(timeout_o), .timeout_sticky_o(timeout_sticky_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Requester state: index 0 = imem, 1 = dmem
  bit          pend [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_we [2];
  // Transaction model: which port owns the bus, how long it has, and its latency
  int          m_port;
  int          m_last;
  int          t_busy;
  int          lat;
  bit          m_sticky;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_we;
  bit          exp_done, exp_to, did_reset;
  logic [31:0] exp_rd;
  int          n_txn [2];
  int          n_to, n_edge;

  task automatic new_payload(input int p);
    p_addr[p]  = $urandom;
    p_wdata[p] = $urandom;
    p_we[p]    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
  endtask

  task automatic drive_ports();
    imem_valid_i = pend[0]; imem_addr_i = p_addr[0]; imem_wdata_i = p_wdata[0]; imem_we_i = p_we[0];
    dmem_valid_i = pend[1]; dmem_addr_i = p_addr[1]; dmem_wdata_i = p_wdata[1]; dmem_we_i = p_we[1];
  endtask

  initial begin
    rst = 1'b1;
    pend[0] = 0; pend[1] = 0;
    for (int p = 0; p < 2; p++) begin new_payload(p); n_txn[p] = 0; end
    drive_ports();
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    m_port = -1; m_last = 0; m_sticky = 0; t_busy = 0; lat = 0;
    n_to = 0; n_edge = 0; did_reset = 0;
    c_addr = '0; c_wdata = '0; c_we = '0;

    repeat (2) @(negedge clk);
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_readies", {imem_ready_o, dmem_ready_o}, 0);
    chk("rst_rdatas", imem_rdata_o | dmem_rdata_o, 0);
    chk("rst_timeout", {timeout_o, timeout_sticky_o}, 0);
    rst = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("mem_valid", mem_valid_o, (m_port >= 0));
      if (m_port >= 0) begin
        chk("mem_addr", mem_addr_o, c_addr);
        chk("mem_wdata", mem_wdata_o, c_wdata);
        chk("mem_we", mem_we_o, c_we);
      end

      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 3) != 0) begin pend[p] = 1; new_payload(p); end
        end else if ($urandom_range(0, 3) == 0) begin
          new_payload(p);
        end
      end
      drive_ports();
      mem_ready_i = (m_port >= 0) ? (t_busy == lat) : 1'($urandom_range(0, 1));
      mem_rdata_i = $urandom;
      #1;

      exp_done = (m_port >= 0) && (t_busy == ((lat < TMO) ? lat : TMO));
      exp_to   = exp_done && (lat > TMO);
      exp_rd   = exp_to ? ERR : mem_rdata_i;
      chk("imem_ready", imem_ready_o, exp_done && m_port == 0);
      chk("dmem_ready", dmem_ready_o, exp_done && m_port == 1);
      chk("imem_rdata", imem_rdata_o, (exp_done && m_port == 0) ? exp_rd : 32'h0);
      chk("dmem_rdata", dmem_rdata_o, (exp_done && m_port == 1) ? exp_rd : 32'h0);
      chk("timeout", timeout_o, exp_to);
      chk("sticky", timeout_sticky_o, m_sticky || exp_to);

      if (!did_reset && cyc >= 1500 && m_port == 0 && !exp_done) begin
        rst = 1'b1;
        #1;
        chk("arst_mem_valid", mem_valid_o, 0);
        chk("arst_imem_ready", imem_ready_o, 0);
        chk("arst_sticky", timeout_sticky_o, 0);
        m_port = -1; m_last = 0; m_sticky = 0;
        pend[0] = 1; new_payload(0); pend[1] = 0;
        imem_valid_i = 1'b0; dmem_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        did_reset = 1;
      end else if (exp_done) begin
        pend[m_port] = 0;
        n_txn[m_port]++;
        if (exp_to) n_to++;
        if (lat == TMO) n_edge++;
        m_sticky = m_sticky || exp_to;
        m_port = -1;
      end else if (m_port >= 0) begin
        t_busy++;
      end else if (pend[0] || pend[1]) begin
        m_port  = (pend[0] && pend[1]) ? 1 - m_last : (pend[1] ? 1 : 0);
        m_last  = m_port;
        t_busy  = 0;
        lat     = $urandom_range(0, 6);
        c_addr  = p_addr[m_port];
        c_wdata = p_wdata[m_port];
        c_we    = p_we[m_port];
      end
    end

    chk("imem_served", n_txn[0] > 0, 1);
    chk("dmem_served", n_txn[1] > 0, 1);
    chk("timeouts_seen", n_to > 0, 1);
    chk("expiry_edge_seen", n_edge > 0, 1);
    chk("reset_exercised", did_reset, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
